product_accumulator: RTL and testbench

Sequential accumulation stage that sits directly downstream of the 8x8 unsigned combinational product stage. It consumes one 16-bit unsigned product per accepted beat and sums a frame of products, delimited by `in_last`, into a wide accumulator. It then presents the frame total, beat count and sticky overflow flag on a valid/ready output port. This turns the combinational multiplier into a usable multiply-accumulate (dot-product) path.

---
 rtl/mac_pkg.sv | 13 +
 rtl/n_bit_carry_ripple_adder.sv | 24 ++
 rtl/product_accumulator.sv | 100 ++++++++++
 tb/tb_product_accumulator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the product multiply-accumulate path.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int PROD_W        = 16;
  localparam int ACC_W_DEFAULT = 24;

endpackage

// File: rtl/n_bit_carry_ripple_adder.sv
// Plain N-bit carry-ripple adder; the carry-out reports modular wrap of the sum.
module n_bit_carry_ripple_adder #(
  parameter int N = 24
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] sum_o,
  output logic         c_o
);

  always_comb begin : ripple
    logic [N:0] carry;
    carry    = '0;
    sum_o    = '0;
    carry[0] = c_i;
    for (int i = 0; i < N; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = carry[N];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a frame of 16-bit unsigned products into a wide accumulator and
// presents total, beat count and sticky wrap flag on a valid/ready port.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              overflow
);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [ACC_W-1:0]   add_a_d;
  logic [ACC_W-1:0]   add_b_d;
  logic [ACC_W-1:0]   sum_d;
  logic               carry_d;
  logic               beat_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A fresh frame starts from zero, so the stale accumulator is masked in IDLE.
  assign add_a_d = (state_q == IDLE) ? '0 : acc_q;
  assign add_b_d = {{(ACC_W-PROD_W){1'b0}}, product};
  assign beat_d  = in_valid & in_ready_q;

  n_bit_carry_ripple_adder #(
    .N(ACC_W)
  ) u_adder (
    .a_i  (add_a_d),
    .b_i  (add_b_d),
    .c_i  (1'b0),
    .sum_o(sum_d),
    .c_o  (carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat_d) begin
            acc_q <= sum_d;
            cnt_q <= (state_q == IDLE) ? CNT_W'(1) : sat_inc(cnt_q);
            ovf_q <= (state_q == IDLE) ? 1'b0 : (ovf_q | carry_d);
            if (in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign beat_cnt  = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with a frame-level reference model.
module tb_product_accumulator;

  localparam int ACC_W = 24;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  beat_cnt;
  logic              overflow;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Reference model: frame total kept as a full-width integer.
  bit     m_hold  = 1'b0;
  longint m_total = 0;
  int     m_n     = 0;

  product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .product  (product),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .beat_cnt (beat_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_hold  <= 1'b0;
      m_total <= 0;
      m_n     <= 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold  <= 1'b0;
        m_total <= 0;
        m_n     <= 0;
      end
    end else if (in_valid) begin
      m_total <= m_total + longint'(product);
      m_n     <= m_n + 1;
      if (in_last) m_hold <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_in_ready", longint'(in_ready), longint'(!m_hold));
      chk("model_out_valid", longint'(out_valid), longint'(m_hold));
      if (m_hold) begin
        chk("model_acc", longint'(acc_out), m_total % (64'd1 << ACC_W));
        chk("model_cnt", longint'(beat_cnt), (m_n > 255) ? 255 : m_n);
        chk("model_ovf", longint'(overflow), longint'(m_total >= (64'd1 << ACC_W)));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic beat(input logic [15:0] p, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    product  = p;
    in_last  = last;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: actual in_ready 0 required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic result(input string nm, input longint acc, input longint cnt,
                        input longint ov);
    chk({nm, "_valid"}, longint'(out_valid), 1);
    chk({nm, "_acc"}, longint'(acc_out), acc);
    chk({nm, "_cnt"}, longint'(beat_cnt), cnt);
    chk({nm, "_ovf"}, longint'(overflow), ov);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic long_frame(input int n);
    for (int i = 0; i < n; i++) beat(16'hFE01, (i == n - 1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; product = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_acc", longint'(acc_out), 0);
    chk("rst_cnt", longint'(beat_cnt), 0);
    chk("rst_ovf", longint'(overflow), 0);
    cmp_en = 1'b1;

    beat(16'h0009, 1'b1);
    result("single", 9, 1, 0);
    chk("bubble_in_ready", longint'(in_ready), 1);

    beat(16'hFFFF, 1'b0); beat(16'h0001, 1'b0);
    beat(16'h00FF, 1'b0); beat(16'hFE01, 1'b1);
    result("four", 24'h01FF00, 4, 0);

    // 257 x 65025 = 0xFEFF01 still fits in 24 bits
    long_frame(257);
    result("sat257", 24'hFEFF01, 255, 0);
    // 260 x 65025 = 0x101F904 wraps; flag stays set after the wrapping add
    long_frame(260);
    result("wrap260", 24'h01F904, 255, 1);

    beat(16'h0010, 1'b1);
    in_valid = 1'b1; product = 16'h0020; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_acc_stable", longint'(acc_out), 16'h0010);
      chk("bp_cnt_stable", longint'(beat_cnt), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_bubble_valid", longint'(out_valid), 0);
    chk("bp_bubble_ready", longint'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    result("bp_new", 16'h0020, 1, 0);

    beat(16'h0001, 1'b0); beat(16'h0002, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", longint'(out_valid), 0);
    chk("midrst_ready", longint'(in_ready), 1);
    beat(16'h0003, 1'b1);
    result("after_rst", 3, 1, 0);

    beat(16'h0005, 1'b0);
    in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
    chk("gap_no_valid", longint'(out_valid), 0);
    beat(16'h0006, 1'b0);
    @(negedge clk);
    beat(16'h0007, 1'b1);
    result("gaps", 18, 3, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
